// File: rtl/vga_fb_fill_ctrl.sv
// rtl/vga_fb_fill_ctrl.sv - framebuffer write-port arbiter: MCU pixel writes plus rectangle-fill engine
//
// Owns the single write port of the 80x60 framebuffer. The MCU writes
// configuration and pixels through its port bus. A GO write starts a
// rectangle fill that emits one pixel per clock. A direct MCU pixel write
// always wins the port for its cycle, and the fill cursor holds during it.
//
// Ports:
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   IO_STRB  MCU output strobe; each high cycle is one port write
//   PORT_ID  MCU port id
//   OUT_PORT MCU output data
//   FB_WA    framebuffer write address {row[5:0], col[6:0]}
//   FB_WD    framebuffer write data
//   FB_WE    framebuffer write enable (single-cycle pulses)
//   BUSY     high while a fill is in progress
module vga_fb_fill_ctrl #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 60,
  parameter logic [7:0] HADDR_ID = 8'h90,
  parameter logic [7:0] LADDR_ID = 8'h91,
  parameter logic [7:0] COLOR_ID = 8'h92,
  parameter logic [7:0] X0_ID    = 8'h94,
  parameter logic [7:0] Y0_ID    = 8'h95,
  parameter logic [7:0] W_ID     = 8'h96,
  parameter logic [7:0] H_ID     = 8'h97,
  parameter logic [7:0] GO_ID    = 8'h98
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IO_STRB,
  input  logic [7:0]  PORT_ID,
  input  logic [7:0]  OUT_PORT,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  output logic        BUSY
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, state_nxt;

  logic [4:0]  haddr;
  logic [7:0]  laddr, x0, y0, w, h;

  // Shadow copies latched at GO; a running fill only looks at these.
  logic [6:0]  sx0, sx0_nxt;
  logic [6:0]  x_end, x_end_nxt;
  logic [5:0]  y_end, y_end_nxt;
  logic [7:0]  colour, colour_nxt;
  logic [6:0]  cur_x, cur_x_nxt;
  logic [5:0]  cur_y, cur_y_nxt;

  logic [12:0] fb_wa_nxt;
  logic [7:0]  fb_wd_nxt;
  logic        fb_we_nxt, busy_nxt;

  logic        color_hit, go_hit, null_fill;
  logic [8:0]  x_sum, y_sum;
  logic [6:0]  x_end_c;
  logic [5:0]  y_end_c;

  assign color_hit = IO_STRB && (PORT_ID == COLOR_ID);
  assign go_hit    = IO_STRB && (PORT_ID == GO_ID);

  // Clipped end coordinates; 9-bit sums so X0+W never wraps.
  assign x_sum   = {1'b0, x0} + {1'b0, w};
  assign y_sum   = {1'b0, y0} + {1'b0, h};
  assign x_end_c = (x_sum > 9'(COLS)) ? 7'(COLS - 1) : (x_sum[6:0] - 7'd1);
  assign y_end_c = (y_sum > 9'(ROWS)) ? 6'(ROWS - 1) : (y_sum[5:0] - 6'd1);

  assign null_fill = (w == 8'd0) || (h == 8'd0) ||
                     (x0 >= 8'(COLS)) || (y0 >= 8'(ROWS));

  // Configuration registers load in any state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      haddr <= '0;
      laddr <= '0;
      x0    <= '0;
      y0    <= '0;
      w     <= '0;
      h     <= '0;
    end else if (IO_STRB) begin
      case (PORT_ID)
        HADDR_ID: haddr <= OUT_PORT[4:0];
        LADDR_ID: laddr <= OUT_PORT;
        X0_ID:    x0    <= OUT_PORT;
        Y0_ID:    y0    <= OUT_PORT;
        W_ID:     w     <= OUT_PORT;
        H_ID:     h     <= OUT_PORT;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      sx0    <= '0;
      x_end  <= '0;
      y_end  <= '0;
      colour <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      FB_WA  <= '0;
      FB_WD  <= '0;
      FB_WE  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sx0    <= sx0_nxt;
      x_end  <= x_end_nxt;
      y_end  <= y_end_nxt;
      colour <= colour_nxt;
      cur_x  <= cur_x_nxt;
      cur_y  <= cur_y_nxt;
      FB_WA  <= fb_wa_nxt;
      FB_WD  <= fb_wd_nxt;
      FB_WE  <= fb_we_nxt;
      BUSY   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sx0_nxt    = sx0;
    x_end_nxt  = x_end;
    y_end_nxt  = y_end;
    colour_nxt = colour;
    cur_x_nxt  = cur_x;
    cur_y_nxt  = cur_y;
    fb_wa_nxt  = FB_WA;
    fb_wd_nxt  = FB_WD;
    fb_we_nxt  = 1'b0;
    busy_nxt   = BUSY;

    if (color_hit) begin
      // Direct write owns the port; a running fill simply holds its cursor.
      fb_we_nxt = 1'b1;
      fb_wa_nxt = {haddr, laddr};
      fb_wd_nxt = OUT_PORT;
    end else begin
      case (state)
        IDLE: begin
          if (go_hit && !null_fill) begin
            state_nxt  = FILL;
            busy_nxt   = 1'b1;
            sx0_nxt    = x0[6:0];
            x_end_nxt  = x_end_c;
            y_end_nxt  = y_end_c;
            colour_nxt = OUT_PORT;
            cur_x_nxt  = x0[6:0];
            cur_y_nxt  = y0[5:0];
          end
        end
        FILL: begin
          fb_we_nxt = 1'b1;
          fb_wa_nxt = {cur_y, cur_x};
          fb_wd_nxt = colour;
          if (cur_x == x_end) begin
            cur_x_nxt = sx0;
            cur_y_nxt = cur_y + 6'd1;
            if (cur_y == y_end) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            cur_x_nxt = cur_x + 7'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_fill_ctrl.sv
// tb/tb_vga_fb_fill_ctrl.sv - self-checking bench for vga_fb_fill_ctrl
module tb_vga_fb_fill_ctrl;

  localparam logic [7:0] HADDR_ID = 8'h90;
  localparam logic [7:0] LADDR_ID = 8'h91;
  localparam logic [7:0] COLOR_ID = 8'h92;
  localparam logic [7:0] X0_ID    = 8'h94;
  localparam logic [7:0] Y0_ID    = 8'h95;
  localparam logic [7:0] W_ID     = 8'h96;
  localparam logic [7:0] H_ID     = 8'h97;
  localparam logic [7:0] GO_ID    = 8'h98;
  localparam int         LIMIT    = 8000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IO_STRB = 1'b0;
  logic [7:0]  PORT_ID = '0;
  logic [7:0]  OUT_PORT = '0;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE;
  logic        BUSY;

  vga_fb_fill_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .IO_STRB(IO_STRB), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .FB_WA(FB_WA), .FB_WD(FB_WD), .FB_WE(FB_WE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Write log and BUSY bookkeeping, sampled on the falling edge.
  int          got_wa[$];
  int          got_wd[$];
  int unsigned got_cyc[$];
  int          busy_total = 0;
  int unsigned busy_rise  = 0;
  logic        busy_prev  = 1'b0;

  always @(negedge CLK) begin
    if (FB_WE === 1'b1) begin
      got_wa.push_back(int'(FB_WA));
      got_wd.push_back(int'(FB_WD));
      got_cyc.push_back(cyc);
    end
    if (BUSY === 1'b1) begin
      busy_total++;
      if (!busy_prev) busy_rise = cyc;
    end
    busy_prev = (BUSY === 1'b1);
  end

  int          total = 0;
  int          bad   = 0;
  int unsigned last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    IO_STRB  = 1'b1;
    PORT_ID  = id;
    OUT_PORT = d;
    @(posedge CLK);
    #1;
    IO_STRB  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int to;
    to = 0;
    while (BUSY === 1'b1 && to < LIMIT) begin
      step();
      to++;
    end
    chk({tag, "_timeout"}, 32'(to < LIMIT), 32'd1);
    repeat (3) step();
  endtask

  // Reference: every in-bounds pixel of the rectangle, row-major.
  task automatic model(input int x0, input int y0, input int w, input int h, output int q[$]);
    q = {};
    for (int y = y0; y < y0 + h && y < 60; y++)
      for (int x = x0; x < x0 + w && x < 80; x++)
        q.push_back(y * 128 + x);
  endtask

  task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                          input int h, input logic [7:0] col);
    int exp_q[$];
    int base, bbase, n;
    int unsigned go;
    model(x0, y0, w, h, exp_q);
    wr(X0_ID, 8'(x0));
    wr(Y0_ID, 8'(y0));
    wr(W_ID, 8'(w));
    wr(H_ID, 8'(h));
    base  = got_wa.size();
    bbase = busy_total;
    wr(GO_ID, col);
    go = last_cyc;
    wait_idle(tag);
    n = got_wa.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    chk({tag, "_busy_cycles"}, 32'(busy_total - bbase), 32'(exp_q.size()));
    if (n == exp_q.size() && n > 0) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_wa%0d", tag, i), 32'(got_wa[base + i]), 32'(exp_q[i]));
        chk($sformatf("%s_wd%0d", tag, i), 32'(got_wd[base + i]), 32'(col));
      end
      chk({tag, "_busy_rise"}, busy_rise, go);
      chk({tag, "_first_we"}, got_cyc[base], go + 1);
      chk({tag, "_last_we"}, got_cyc[base + n - 1], go + 32'(n));
    end
  endtask

  initial begin
    int base, bbase;
    int unsigned cc;
    int exp_wa[$];
    int exp_wd[$];

    // Reset state
    #12;
    chk("rst_we", 32'(FB_WE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wa", 32'(FB_WA), 32'd0);
    chk("rst_wd", 32'(FB_WD), 32'd0);
    step();
    RESET_N = 1'b1;
    step();

    // Direct write
    base = got_wa.size();
    wr(HADDR_ID, 8'h02);
    wr(LADDR_ID, 8'h03);
    wr(COLOR_ID, 8'h1C);
    cc = last_cyc;
    repeat (3) step();
    chk("direct_count", 32'(got_wa.size() - base), 32'd1);
    if (got_wa.size() - base == 1) begin
      chk("direct_wa", 32'(got_wa[base]), 32'h0203);
      chk("direct_wd", 32'(got_wd[base]), 32'h1C);
      chk("direct_latency", got_cyc[base], cc);
    end

    // Directed fills
    run_fill("fill2x2", 3, 4, 2, 2, 8'hE0);
    run_fill("clip", 78, 59, 5, 3, 8'hFF);
    run_fill("null_x", 80, 5, 4, 2, 8'h11);
    run_fill("null_w", 5, 5, 0, 2, 8'h22);
    run_fill("null_y", 5, 60, 3, 2, 8'h33);

    // Collision on the second fill cycle of a 4x1 fill at (0,0)
    wr(HADDR_ID, 8'h10);
    wr(LADDR_ID, 8'h00);
    wr(X0_ID, 8'd0);
    wr(Y0_ID, 8'd0);
    wr(W_ID, 8'd4);
    wr(H_ID, 8'd1);
    base  = got_wa.size();
    bbase = busy_total;
    wr(GO_ID, 8'h5A);
    step();
    wr(COLOR_ID, 8'h03);
    wait_idle("coll");
    exp_wa = '{'h000, 'h1000, 'h001, 'h002, 'h003};
    exp_wd = '{'h5A, 'h03, 'h5A, 'h5A, 'h5A};
    chk("coll_count", 32'(got_wa.size() - base), 32'd5);
    chk("coll_busy_cycles", 32'(busy_total - bbase), 32'd5);
    if (got_wa.size() - base == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("coll_wa%0d", i), 32'(got_wa[base + i]), 32'(exp_wa[i]));
        chk($sformatf("coll_wd%0d", i), 32'(got_wd[base + i]), 32'(exp_wd[i]));
      end
    end

    // GO and config writes while busy are ignored by the running fill
    model(10, 10, 8, 8, exp_wa);
    wr(X0_ID, 8'd10);
    wr(Y0_ID, 8'd10);
    wr(W_ID, 8'd8);
    wr(H_ID, 8'd8);
    base = got_wa.size();
    wr(GO_ID, 8'h55);
    wr(W_ID, 8'd1);
    wr(GO_ID, 8'h00);
    wait_idle("busy");
    chk("busy_count", 32'(got_wa.size() - base), 32'd64);
    if (got_wa.size() - base == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk($sformatf("busy_wa%0d", i), 32'(got_wa[base + i]), 32'(exp_wa[i]));
        chk($sformatf("busy_wd%0d", i), 32'(got_wd[base + i]), 32'h55);
      end
    end

    // Randomized fills against the reference model
    for (int i = 0; i < 12; i++)
      run_fill($sformatf("rnd%0d", i), int'($urandom_range(0, 90)), int'($urandom_range(0, 66)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 10)), 8'($urandom));

    // Asynchronous reset mid-fill
    wr(X0_ID, 8'd0);
    wr(Y0_ID, 8'd0);
    wr(W_ID, 8'd10);
    wr(H_ID, 8'd10);
    wr(GO_ID, 8'h44);
    repeat (5) step();
    #3;
    RESET_N = 1'b0;
    #1;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_we", 32'(FB_WE), 32'd0);
    chk("midrst_wa", 32'(FB_WA), 32'd0);
    base  = got_wa.size();
    bbase = busy_total;
    step();
    step();
    RESET_N = 1'b1;
    repeat (20) step();
    chk("midrst_no_writes", 32'(got_wa.size() - base), 32'd0);
    chk("midrst_no_busy", 32'(busy_total - bbase), 32'd0);
    wr(GO_ID, 8'h07);
    repeat (10) step();
    chk("postrst_go_writes", 32'(got_wa.size() - base), 32'd0);
    chk("postrst_go_busy", 32'(busy_total - bbase), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
